// File: rtl/decode_lanes.sv
// Multi-lane decode stage: classifies branch/jump lanes, squashes lanes after
// the first jump, and buffers bundles through an OUT register plus a skid entry.
module decode_lanes #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LANES      = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ADDR_WIDTH-3:0]            in_addr,
    input  logic [32*LANES-1:0]              in_insn,
    input  logic [LANES-1:0]                 in_lane_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [(ADDR_WIDTH-2)*LANES-1:0]  out_addr,
    output logic [32*LANES-1:0]              out_insn,
    output logic [LANES-1:0]                 out_lane_valid,
    output logic [LANES-1:0]                 out_is_branch,
    output logic [LANES-1:0]                 out_is_jump,
    output logic [31:0]                      insn_count
);

    localparam int unsigned WA = ADDR_WIDTH - 2;
    localparam int unsigned CW = $clog2(LANES + 1);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [WA*LANES-1:0] w_addr;
    logic [LANES-1:0]    w_lv;
    logic [LANES-1:0]    w_br;
    logic [LANES-1:0]    w_jp;
    logic                w_jump_seen;
    logic [6:0]          w_opc;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic [CW-1:0]       w_pop;

    logic                r_out_valid;
    logic [WA*LANES-1:0] r_out_addr;
    logic [32*LANES-1:0] r_out_insn;
    logic [LANES-1:0]    r_out_lv;
    logic [LANES-1:0]    r_out_br;
    logic [LANES-1:0]    r_out_jp;

    logic                r_skid_valid;
    logic [WA*LANES-1:0] r_skid_addr;
    logic [32*LANES-1:0] r_skid_insn;
    logic [LANES-1:0]    r_skid_lv;
    logic [LANES-1:0]    r_skid_br;
    logic [LANES-1:0]    r_skid_jp;

    logic [31:0]         r_count;

    // Decode the incoming bundle; a lane is squashed once an older valid jump is seen
    always_comb begin
        w_addr      = '0;
        w_lv        = '0;
        w_br        = '0;
        w_jp        = '0;
        w_jump_seen = 1'b0;
        w_opc       = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_opc               = in_insn[32*i +: 7];
            w_addr[WA*i +: WA]  = in_addr + WA'(i);
            w_lv[i]             = in_lane_mask[i] && !w_jump_seen;
            w_br[i]             = w_lv[i] && (w_opc == OP_BRANCH);
            w_jp[i]             = w_lv[i] && ((w_opc == OP_JAL) || (w_opc == OP_JALR));
            if (w_jp[i]) begin
                w_jump_seen = 1'b1;
            end
        end
    end

    assign w_in_xfer  = in_valid && !r_skid_valid;
    assign w_out_xfer = r_out_valid && out_ready;

    // Popcount of the bundle currently presented
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_pop = w_pop + CW'(r_out_lv[i]);
        end
    end

    // OUT / SKID storage; skid only ever holds data while OUT is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_insn   <= '0;
            r_out_lv     <= '0;
            r_out_br     <= '0;
            r_out_jp     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_addr  <= '0;
            r_skid_insn  <= '0;
            r_skid_lv    <= '0;
            r_skid_br    <= '0;
            r_skid_jp    <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid && w_out_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_addr   <= r_skid_addr;
            r_out_insn   <= r_skid_insn;
            r_out_lv     <= r_skid_lv;
            r_out_br     <= r_skid_br;
            r_out_jp     <= r_skid_jp;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_out_xfer) begin
            r_out_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_out_addr <= w_addr;
                r_out_insn <= in_insn;
                r_out_lv   <= w_lv;
                r_out_br   <= w_br;
                r_out_jp   <= w_jp;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_addr  <= w_addr;
            r_skid_insn  <= in_insn;
            r_skid_lv    <= w_lv;
            r_skid_br    <= w_br;
            r_skid_jp    <= w_jp;
        end
    end

    // Delivered-lane counter; a transfer coincident with flush still counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_out_xfer) begin
            r_count <= r_count + 32'(w_pop);
        end
    end

    assign in_ready       = !r_skid_valid;
    assign out_valid      = r_out_valid;
    assign out_addr       = r_out_addr;
    assign out_insn       = r_out_insn;
    assign out_lane_valid = r_out_lv;
    assign out_is_branch  = r_out_br;
    assign out_is_jump    = r_out_jp;
    assign insn_count     = r_count;

endmodule
